tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_ctrl_pkg.sv | 36 +++
 rtl/tff_count_ctrl_if.sv | 29 ++
 rtl/tff_cell.sv | 19 +
 rtl/tff_count_ctrl.sv | 130 +++++++++++++
 tb/tb_tff_count_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T flip-flop bank controller.
//   state_t            : controller FSM state encoding (IDLE, INIT, RUN, DONE)
//   MODE_*             : command mode encodings carried on cmd_mode
//   bin2gray/gray2bin  : code conversions at FUNC_W bits; callers zero-extend
//                        narrower values and truncate the result.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    localparam int FUNC_W = 32;

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Command/status bundle between a command source and tff_count_ctrl.
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_mode/cmd_limit  : command mode and terminal bank value
//   abort               : cancel a running command
//   t_vec/q             : toggle vector and current bank state
//   busy/done           : activity flag and one-cycle completion pulse
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [WIDTH-1:0] cmd_limit;
    logic             abort;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_mode, cmd_limit, abort,
        input  cmd_ready, t_vec, q, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_limit, abort,
        output cmd_ready, t_vec, q, busy, done
    );
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop of the controlled bank.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears A0
//   T   : toggle enable
//   A0  : stored bit
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic A0
);
    always_ff @(posedge clk) begin
        if (rst) begin
            A0 <= 1'b0;
        end else begin
            A0 <= A0 ^ T;
        end
    end
endmodule

// File: rtl/tff_count_ctrl.sv
// Controller driving a bank of WIDTH T flip-flops through count sequences
// (binary up, binary down, Gray up, hold). The bank only ever changes by
// toggling; the controller computes the toggle vector from the current state
// and bank value and stores nothing but its state, mode and limit.
//   clk, rst : clock and synchronous active-high reset
//   bus      : command/status bundle (slave side), see tff_count_ctrl_if
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    tff_count_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] down_t;
    logic [WIDTH-1:0] gray_bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             busy;
    logic             ready;
    logic             done;
    logic             accept;

    assign accept = (state_q == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields are pure data; they are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q  <= bus.cmd_mode;
            limit_q <= bus.cmd_limit;
        end
    end

    // Ripple-carry style toggle masks: a bit toggles when every lower bit is
    // 1 (counting up) or 0 (counting down).
    always_comb begin
        up_t      = '0;
        down_t    = '0;
        up_t[0]   = 1'b1;
        down_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i]   = up_t[i-1] & q[i-1];
            down_t[i] = down_t[i-1] & ~q[i-1];
        end
    end

    // Next Gray code; the sum is truncated to WIDTH so the sequence wraps.
    assign gray_bin_nxt = WIDTH'(gray2bin(FUNC_W'(q))) + WIDTH'(1);
    assign gray_nxt     = WIDTH'(bin2gray(FUNC_W'(gray_bin_nxt)));

    always_comb begin
        state_d = state_q;
        t_vec   = '0;
        busy    = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                busy = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    // Steer the bank onto the sequence start in one step.
                    t_vec   = q ^ ((mode_q == MODE_DOWN) ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if ((q == limit_q) || (mode_q == MODE_HOLD)) begin
                    state_d = DONE;
                end else begin
                    case (mode_q)
                        MODE_UP:   t_vec = up_t;
                        MODE_DOWN: t_vec = down_t;
                        MODE_GRAY: t_vec = q ^ gray_nxt;
                        default:   t_vec = '0;
                    endcase
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .T   (t_vec[i]),
            .A0  (q[i])
        );
    end

    assign bus.cmd_ready = ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.t_vec     = t_vec;
    assign bus.q         = q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Testbench for tff_count_ctrl: directed command scenarios followed by
// randomized commands with random aborts and mid-run resets. Expected bank
// values come from the arithmetic sequence each mode walks through.
module tb_tff_count_ctrl;
    import tff_ctrl_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mq;

    tff_count_ctrl_if #(.WIDTH(W)) bus ();

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, ".busy"},  32'(bus.busy),      32'd0);
        chk({tag, ".done"},  32'(bus.done),      32'd0);
        chk({tag, ".t_vec"}, 32'(bus.t_vec),     32'd0);
        chk({tag, ".q"},     32'(bus.q),         32'(mq));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b0;
            bus.abort     = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            check_idle("idle");
            tick();
        end
    endtask

    // abort_at / rst_at: cycle index after the accept edge (-1 = never).
    task automatic run_cmd(input logic [1:0] mode, input int limit,
                           input int abort_at, input int rst_at);
        int seq[$];
        int v;
        int b;
        int n;
        int ab;
        int rs;
        if (mode == MODE_HOLD) begin
            seq.push_back(0);
        end else begin
            v = (mode == MODE_DOWN) ? MASK : 0;
            b = 0;
            seq.push_back(v);
            while (v != limit) begin
                if (mode == MODE_UP) v = (v + 1) & MASK;
                else if (mode == MODE_DOWN) v = (v - 1) & MASK;
                else begin
                    b = (b + 1) & MASK;
                    v = b ^ (b >> 1);
                end
                seq.push_back(v);
            end
        end
        n  = seq.size() - 1;
        ab = (abort_at <= n + 1) ? abort_at : -1;
        rs = (rst_at <= n + 1) ? rst_at : -1;

        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_limit = limit[W-1:0];
        bus.abort     = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        check_idle("accept");
        tick();

        for (int k = 0; k <= n + 2; k++) begin
            int qk;
            int qn;
            int texp;
            qk = (k == 0) ? mq : seq[(k - 1 > n) ? n : k - 1];
            qn = seq[(k > n) ? n : k];
            texp = (k == ab || k > n + 1) ? 0 : (qk ^ qn);
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_mode  = 2'($urandom);
            bus.cmd_limit = W'($urandom);
            bus.abort     = (k == ab) ? 1'b1 : ((k == n + 2) && ($urandom_range(0, 1) == 0));
            rst           = (k == rs);
            @(negedge clk);
            chk("run.q",     32'(bus.q),         32'(qk));
            chk("run.busy",  32'(bus.busy),      32'(k <= n + 1));
            chk("run.done",  32'(bus.done),      32'(k == n + 2));
            chk("run.ready", 32'(bus.cmd_ready), 32'd0);
            chk("run.t_vec", 32'(bus.t_vec),     32'(texp));
            if (mode == MODE_GRAY && k >= 1 && k <= n && k != ab)
                chk("gray.onehot", 32'($countones(bus.t_vec)), 32'd1);
            tick();
            if (k == ab) begin
                bus.abort = 1'b0;
                mq = qk;
                return;
            end
            if (k == rs) begin
                rst = 1'b0;
                mq  = 0;
                return;
            end
        end
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        mq = seq[n];
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = MODE_DOWN;
        bus.cmd_limit = W'(3);
        bus.abort     = 1'b0;
        mq            = 0;
        repeat (3) tick();
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_idle("reset");
        tick();

        run_cmd(MODE_UP,   5,  -1, -1);
        run_cmd(MODE_DOWN, 10, -1, -1);
        run_cmd(MODE_GRAY, 6,  -1, -1);
        run_cmd(MODE_UP,   9,   4, -1);
        idle_cycles(1);
        run_cmd(MODE_HOLD, 7,  -1, -1);
        run_cmd(MODE_UP,   0,  -1, -1);
        run_cmd(MODE_UP,   15, -1,  8);

        for (int i = 0; i < 80; i++) begin
            int ab;
            int rs;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 17)) : -1;
            rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 17)) : -1;
            run_cmd(2'($urandom), int'($urandom_range(0, MASK)), ab, rs);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
